// File: rtl/multi_ball_physics_if.sv
// Frame-control, per-ball event and position signals of multi_ball_physics.
// master drives the events and frame strobe; slave is the physics engine.
interface multi_ball_physics_if #(
  parameter int NUM_BALLS = 2
);
  logic                     startOfFrame;
  logic [NUM_BALLS-1:0]     launch;
  logic [NUM_BALLS-1:0]     loss;
  logic [NUM_BALLS-1:0]     collision;
  logic [4*NUM_BALLS-1:0]   HitEdgeCode;
  logic [11*NUM_BALLS-1:0]  topLeftX;
  logic [11*NUM_BALLS-1:0]  topLeftY;
  logic [NUM_BALLS-1:0]     active;
  logic                     busy;
  logic                     overrun;

  modport master (
    output startOfFrame, launch, loss, collision, HitEdgeCode,
    input  topLeftX, topLeftY, active, busy, overrun
  );

  modport slave (
    input  startOfFrame, launch, loss, collision, HitEdgeCode,
    output topLeftX, topLeftY, active, busy, overrun
  );
endinterface

// File: rtl/multi_ball_physics.sv
// Fixed-point multi-ball physics; each frame sweeps the balls, one per clock.
// Optional: define BALL_BOUNDS_CLAMP_EN to clamp positions to the visible screen.
module multi_ball_physics #(
  parameter int NUM_BALLS      = 2,
  parameter int FRAC_BITS      = 6,
  parameter int INITIAL_X      = 392,
  parameter int INITIAL_Y      = 337,
  parameter int LAUNCH_SPEED   = 160,
  parameter int MAX_SPEED      = 500,
  parameter int GRAVITY        = 1,
  parameter int FRICTION_SHIFT = 5
) (
  input logic                 clk,
  input logic                 resetN,
  multi_ball_physics_if.slave bus
);

  localparam int PosW = 11 + FRAC_BITS;
  localparam int IdxW = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;

  typedef logic signed [PosW-1:0] pos_t;
  typedef logic signed [15:0]     spd_t;
  typedef logic signed [17:0]     wide_t;
  typedef logic signed [10:0]     pix_t;

  typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

  localparam pos_t  InitXFp  = pos_t'(INITIAL_X * (2 ** FRAC_BITS));
  localparam pos_t  InitYFp  = pos_t'(INITIAL_Y * (2 ** FRAC_BITS));
  localparam spd_t  LaunchVy = spd_t'(-LAUNCH_SPEED);
  localparam wide_t MaxSpdW  = wide_t'(MAX_SPEED);
  localparam wide_t GravW    = wide_t'(GRAVITY);
`ifdef BALL_BOUNDS_CLAMP_EN
  localparam pix_t  MaxPixX  = pix_t'(639 - 15);
  localparam pix_t  MaxPixY  = pix_t'(479 - 15);
  localparam pos_t  MaxXFp   = pos_t'((639 - 15) * (2 ** FRAC_BITS));
  localparam pos_t  MaxYFp   = pos_t'((479 - 15) * (2 ** FRAC_BITS));
`endif

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                overrun_q, overrun_d;

  pos_t                x_q  [NUM_BALLS];
  pos_t                x_d  [NUM_BALLS];
  pos_t                y_q  [NUM_BALLS];
  pos_t                y_d  [NUM_BALLS];
  spd_t                vx_q [NUM_BALLS];
  spd_t                vx_d [NUM_BALLS];
  spd_t                vy_q [NUM_BALLS];
  spd_t                vy_d [NUM_BALLS];
  pix_t                xo_q [NUM_BALLS];
  pix_t                yo_q [NUM_BALLS];
  logic [NUM_BALLS-1:0] active_q, active_d;
  logic [NUM_BALLS-1:0] pend_rx_q, pend_rx_d;
  logic [NUM_BALLS-1:0] pend_ry_q, pend_ry_d;
  logic [NUM_BALLS-1:0] pend_launch_q, pend_launch_d;

  // Reflection with friction: keep v - v/2^shift and reverse direction.
  function automatic spd_t reflect(spd_t v);
    spd_t kept;
    kept = v - (v >>> FRICTION_SHIFT);
    return -kept;
  endfunction

  function automatic spd_t clamp_spd(wide_t v);
    if (v > MaxSpdW) begin
      return spd_t'(MaxSpdW);
    end else if (v < -MaxSpdW) begin
      return spd_t'(-MaxSpdW);
    end
    return spd_t'(v);
  endfunction

  function automatic pix_t pix(pos_t p);
    return pix_t'(p >>> FRAC_BITS);
  endfunction

  // Frame sequencer
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q | (bus.startOfFrame & (state_q != StIdle));
    unique case (state_q)
      StIdle: begin
        if (bus.startOfFrame) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      StSweep: begin
        if (idx_q == IdxW'(NUM_BALLS - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Per-ball next state: sweep update, then event flags (set beats clear), then loss.
  always_comb begin
    spd_t       vx_r, vy_r, vx_n, vy_n;
    pos_t       x_n, y_n;
    logic [3:0] code;
`ifdef BALL_BOUNDS_CLAMP_EN
    pix_t       px;
`endif
    active_d      = active_q;
    pend_rx_d     = pend_rx_q;
    pend_ry_d     = pend_ry_q;
    pend_launch_d = pend_launch_q;
    for (int i = 0; i < NUM_BALLS; i++) begin
      x_d[i]  = x_q[i];
      y_d[i]  = y_q[i];
      vx_d[i] = vx_q[i];
      vy_d[i] = vy_q[i];

      vx_r = pend_rx_q[i] ? reflect(vx_q[i]) : vx_q[i];
      vy_r = pend_ry_q[i] ? reflect(vy_q[i]) : vy_q[i];
      x_n  = x_q[i] + pos_t'(vx_r);
      y_n  = y_q[i] + pos_t'(vy_r);
      vx_n = clamp_spd(wide_t'(vx_r));
      vy_n = clamp_spd(wide_t'(vy_r) + GravW);
`ifdef BALL_BOUNDS_CLAMP_EN
      px = pix(x_n);
      if (px[10]) begin
        x_n  = '0;
        vx_n = '0;
      end else if (px > MaxPixX) begin
        x_n  = MaxXFp;
        vx_n = '0;
      end
      px = pix(y_n);
      if (px[10]) begin
        y_n  = '0;
        vy_n = '0;
      end else if (px > MaxPixY) begin
        y_n  = MaxYFp;
        vy_n = '0;
      end
`endif

      if ((state_q == StSweep) && (idx_q == IdxW'(i))) begin
        if (active_q[i]) begin
          x_d[i]  = x_n;
          y_d[i]  = y_n;
          vx_d[i] = vx_n;
          vy_d[i] = vy_n;
        end else if (pend_launch_q[i]) begin
          vx_d[i]     = '0;
          vy_d[i]     = LaunchVy;
          active_d[i] = 1'b1;
        end
        pend_rx_d[i]     = 1'b0;
        pend_ry_d[i]     = 1'b0;
        pend_launch_d[i] = 1'b0;
      end

      // Only reflect when moving into the edge that was hit.
      code = bus.HitEdgeCode[4*i +: 4];
      if (bus.collision[i]) begin
        if ((code[1] && !vx_q[i][15] && (vx_q[i] != '0)) || (code[3] && vx_q[i][15])) begin
          pend_rx_d[i] = 1'b1;
        end
        if ((code[0] && !vy_q[i][15] && (vy_q[i] != '0)) || (code[2] && vy_q[i][15])) begin
          pend_ry_d[i] = 1'b1;
        end
      end
      if (bus.launch[i] && !active_q[i]) begin
        pend_launch_d[i] = 1'b1;
      end

      if (bus.loss[i]) begin
        x_d[i]           = InitXFp;
        y_d[i]           = InitYFp;
        vx_d[i]          = '0;
        vy_d[i]          = '0;
        active_d[i]      = 1'b0;
        pend_rx_d[i]     = 1'b0;
        pend_ry_d[i]     = 1'b0;
        pend_launch_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      overrun_q     <= 1'b0;
      active_q      <= '0;
      pend_rx_q     <= '0;
      pend_ry_q     <= '0;
      pend_launch_q <= '0;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]  <= InitXFp;
        y_q[i]  <= InitYFp;
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        xo_q[i] <= pix(InitXFp);
        yo_q[i] <= pix(InitYFp);
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      overrun_q     <= overrun_d;
      active_q      <= active_d;
      pend_rx_q     <= pend_rx_d;
      pend_ry_q     <= pend_ry_d;
      pend_launch_q <= pend_launch_d;
      for (int i = 0; i < NUM_BALLS; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        vx_q[i] <= vx_d[i];
        vy_q[i] <= vy_d[i];
        xo_q[i] <= pix(x_d[i]);
        yo_q[i] <= pix(y_d[i]);
      end
    end
  end

  for (genvar g = 0; g < NUM_BALLS; g++) begin : g_out
    assign bus.topLeftX[11*g +: 11] = xo_q[g];
    assign bus.topLeftY[11*g +: 11] = yo_q[g];
  end

  assign bus.active  = active_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_multi_ball_physics.sv
// Bench for multi_ball_physics: hand-derived vector table, directed corner cases,
// and random frames checked against a frame-level reference model.
module tb_multi_ball_physics;
  localparam int NB = 4;

  logic clk;
  logic resetN;
  int   vectors;
  int   miscompares;

  multi_ball_physics_if #(.NUM_BALLS(NB)) bus ();

  multi_ball_physics #(.NUM_BALLS(NB)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fixed-point positions (17-bit wrap), speeds, flags per ball.
  int mx [NB];
  int my [NB];
  int mvx[NB];
  int mvy[NB];
  bit mact[NB];
  bit mrx[NB];
  bit mry[NB];
  bit mla[NB];

  function automatic int wrap17(int p);
    int r;
    r = p & 'h1FFFF;
    if (r >= 'h10000) r -= 'h20000;
    return r;
  endfunction

  function automatic int fric(int v);
    return -(v - (v >>> 5));
  endfunction

  function automatic int lim(int v);
    if (v > 500) return 500;
    if (v < -500) return -500;
    return v;
  endfunction

  task automatic model_park(input int i);
    mx[i] = 392 * 64; my[i] = 337 * 64; mvx[i] = 0; mvy[i] = 0;
    mact[i] = 0; mrx[i] = 0; mry[i] = 0; mla[i] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) model_park(i);
  endtask

  task automatic model_event(input logic [NB-1:0] l, input logic [NB-1:0] c,
                             input logic [4*NB-1:0] code, input logic [NB-1:0] s);
    logic [3:0] cd;
    for (int i = 0; i < NB; i++) begin
      cd = code[4*i +: 4];
      if (s[i]) begin
        model_park(i);
      end else begin
        if (c[i]) begin
          if ((cd[1] && mvx[i] > 0) || (cd[3] && mvx[i] < 0)) mrx[i] = 1;
          if ((cd[0] && mvy[i] > 0) || (cd[2] && mvy[i] < 0)) mry[i] = 1;
        end
        if (l[i] && !mact[i]) mla[i] = 1;
      end
    end
  endtask

  task automatic model_frame();
    int vx, vy;
    for (int i = 0; i < NB; i++) begin
      if (mact[i]) begin
        vx = mrx[i] ? fric(mvx[i]) : mvx[i];
        vy = mry[i] ? fric(mvy[i]) : mvy[i];
        mx[i]  = wrap17(mx[i] + vx);
        my[i]  = wrap17(my[i] + vy);
        mvx[i] = lim(vx);
        mvy[i] = lim(vy + 1);
      end else if (mla[i]) begin
        mvx[i] = 0; mvy[i] = -160; mact[i] = 1;
      end
      mrx[i] = 0; mry[i] = 0; mla[i] = 0;
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pix_x(input int i);
    logic [10:0] v;
    v = bus.topLeftX[11*i +: 11];
    return int'($signed(v));
  endfunction

  function automatic int pix_y(input int i);
    logic [10:0] v;
    v = bus.topLeftY[11*i +: 11];
    return int'($signed(v));
  endfunction

  task automatic check_balls(input string name);
    for (int i = 0; i < NB; i++) begin
      check($sformatf("%s x[%0d]", name, i), pix_x(i), mx[i] >>> 6);
      check($sformatf("%s y[%0d]", name, i), pix_y(i), my[i] >>> 6);
      check($sformatf("%s active[%0d]", name, i), int'(bus.active[i]), int'(mact[i]));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    bus.startOfFrame = 1'b0; bus.launch = '0; bus.loss = '0;
    bus.collision = '0; bus.HitEdgeCode = '0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  task automatic apply_events(input logic [NB-1:0] l, input logic [NB-1:0] c,
                              input logic [4*NB-1:0] code, input logic [NB-1:0] s);
    @(negedge clk);
    bus.launch = l; bus.collision = c; bus.HitEdgeCode = code; bus.loss = s;
    model_event(l, c, code, s);
    @(negedge clk);
    bus.launch = '0; bus.collision = '0; bus.HitEdgeCode = '0; bus.loss = '0;
  endtask

  task automatic run_frame(input string name);
    int n;
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    n = 0;
    while (bus.busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      vectors++;
      miscompares++;
      $display("FAIL %s busy_timeout: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  typedef struct {
    logic [NB-1:0]   launch;
    logic [NB-1:0]   coll;
    logic [4*NB-1:0] code;
    logic [NB-1:0]   loss;
    bit              frame;
    int              exp_x0;
    int              exp_y0;
    bit              exp_act0;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int cnt;
    logic [NB-1:0]   l, c, s;
    logic [4*NB-1:0] code;

    vectors = 0;
    miscompares = 0;
    resetN = 1'b1;
    bus.startOfFrame = 1'b0; bus.launch = '0; bus.loss = '0;
    bus.collision = '0; bus.HitEdgeCode = '0;

    // Ball 0 trajectory, derived by hand from the update rules.
    tbl[0] = '{4'b0001, 4'b0000, 16'h0000, 4'b0000, 1, 392, 337, 1}; // launch, y unchanged
    tbl[1] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 1, 392, 334, 1}; // 21408 fp
    tbl[2] = '{4'b0001, 4'b0000, 16'h0000, 4'b0000, 1, 392, 332, 1}; // launch ignored
    tbl[3] = '{4'b0000, 4'b0001, 16'h0004, 4'b0000, 1, 392, 334, 1}; // top hit, vy -158 -> +153
    tbl[4] = '{4'b0000, 4'b0001, 16'h0004, 4'b0000, 1, 392, 336, 1}; // top while falling: none
    tbl[5] = '{4'b0000, 4'b0001, 16'h0001, 4'b0000, 1, 392, 334, 1}; // bottom, 155 -> -151
    tbl[6] = '{4'b0000, 4'b0000, 16'h0000, 4'b0001, 0, 392, 337, 0}; // loss parks at once
    tbl[7] = '{4'b0000, 4'b0000, 16'h0000, 4'b0000, 1, 392, 337, 0}; // parked ball stays

    do_reset();
    check("reset busy", int'(bus.busy), 0);
    check("reset overrun", int'(bus.overrun), 0);
    check_balls("reset");

    for (int k = 0; k < 8; k++) begin
      apply_events(tbl[k].launch, tbl[k].coll, tbl[k].code, tbl[k].loss);
      if (tbl[k].frame) run_frame($sformatf("tbl%0d", k));
      check($sformatf("tbl%0d x0", k), pix_x(0), tbl[k].exp_x0);
      check($sformatf("tbl%0d y0", k), pix_y(0), tbl[k].exp_y0);
      check($sformatf("tbl%0d active0", k), int'(bus.active[0]), int'(tbl[k].exp_act0));
    end

    // Reset in the middle of a sweep leaves nothing of the partial update.
    do_reset();
    apply_events('1, '0, '0, '0);
    run_frame("pre_abort");
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
    check("abort busy", int'(bus.busy), 0);
    check_balls("abort");

    // Second startOfFrame two cycles into the sweep: ignored, flags overrun.
    apply_events('1, '0, '0, '0);
    run_frame("pre_ovr");
    model_frame();
    run_frame("pre_ovr2");
    model_frame();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    cnt = int'(bus.busy);
    @(negedge clk);
    cnt += int'(bus.busy);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    cnt += int'(bus.busy);
    repeat (6) begin
      @(negedge clk);
      cnt += int'(bus.busy);
    end
    model_frame();
    check("ovr busy_cycles", cnt, NB + 1);
    check("ovr overrun", int'(bus.overrun), 1);
    check_balls("ovr");

    // loss[1] during ball 1's sweep slot wins over the update.
    do_reset();
    apply_events('1, '0, '0, '0);
    run_frame("pre_loss");
    model_frame();
    run_frame("pre_loss2");
    model_frame();
    @(negedge clk);
    bus.startOfFrame = 1'b1;
    @(negedge clk);
    bus.startOfFrame = 1'b0;
    @(negedge clk);
    bus.loss = 4'b0010;
    @(negedge clk);
    bus.loss = '0;
    repeat (6) @(negedge clk);
    model_frame();
    model_park(1);
    check_balls("loss_slot");

    // Random events between frames against the reference model.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      l    = NB'($urandom);
      c    = NB'($urandom);
      code = (4*NB)'($urandom);
      s    = ($urandom_range(0, 7) == 0) ? NB'(1 << $urandom_range(0, NB - 1)) : '0;
      apply_events(l, c, code, s);
      run_frame($sformatf("rnd%0d", it));
      model_frame();
      check_balls($sformatf("rnd%0d", it));
      check($sformatf("rnd%0d overrun", it), int'(bus.overrun), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multi_ball_physics.md
MULTI_BALL_PHYSICS -- requirements
Module: multi_ball_physics

Interface
REQ-001 The block SHALL have parameter NUM_BALLS, default 2, giving the ball channel count (1..8).
REQ-002 The block SHALL have parameter FRAC_BITS, default 6, giving the fixed-point fraction bits of position and speed.
REQ-003 The block SHALL have parameters INITIAL_X and INITIAL_Y, defaults 392 and 337, giving the park position in pixels.
REQ-004 The block SHALL have parameter LAUNCH_SPEED, default 160, the upward Y speed set at launch (fixed-point units).
REQ-005 The block SHALL have parameter MAX_SPEED, default 500, the speed magnitude limit per axis.
REQ-006 The block SHALL have parameter GRAVITY, default 1, added to Y speed once per frame.
REQ-007 The block SHALL have parameter FRICTION_SHIFT, default 5: a reflection keeps v - (v>>>FRICTION_SHIFT).
REQ-008 Ports (name  direction  width  meaning), one per line:
 clk  in  1  single clock
 resetN  in  1  synchronous active-low reset
 startOfFrame  in  1  one-cycle pulse per video frame
 launch  in  NUM_BALLS  per-ball launch request
 loss  in  NUM_BALLS  per-ball drain; park the ball
 collision  in  NUM_BALLS  per-ball collision strobe
 HitEdgeCode  in  4*NUM_BALLS  per-ball edge code [4i+3:4i]; bit0 bottom, bit1 right, bit2 top, bit3 left
 topLeftX  out  11*NUM_BALLS  per-ball signed pixel X
 topLeftY  out  11*NUM_BALLS  per-ball signed pixel Y
 active  out  NUM_BALLS  ball in play
 busy  out  1  update sweep in progress
 overrun  out  1  sticky; startOfFrame arrived while busy

Function
REQ-009 The block SHALL keep, per ball, a signed position (11+FRAC_BITS bits), a signed 16-bit Xspeed and Yspeed, an active bit, and pending reflect-X, reflect-Y and launch flags.
REQ-010 When collision[i]=1, the block SHALL set pend_rx[i] if (bit1 and Xspeed>0) or (bit3 and Xspeed<0), and SHALL set pend_ry[i] if (bit0 and Yspeed>0) or (bit2 and Yspeed<0); corner codes can set both flags.
REQ-011 launch[i] SHALL set pend_launch[i] only while active[i]=0; launch while active SHALL be ignored.
REQ-012 The FSM SHALL have states IDLE, SWEEP and DONE; IDLE->SWEEP on startOfFrame; in SWEEP it SHALL update ball idx, one per cycle, from idx=0 to NUM_BALLS-1; SWEEP->DONE after the last ball; DONE->IDLE after one cycle.
REQ-013 busy SHALL be 1 in SWEEP and DONE, so sweep latency is NUM_BALLS+1 cycles after the startOfFrame cycle.
REQ-014 Per-ball update order for an active ball SHALL be: apply the pending reflections (v := -(v - (v>>>FRICTION_SHIFT))), then pos += speed, then Yspeed += GRAVITY, then clamp each axis to [-MAX_SPEED, MAX_SPEED].
REQ-015 For an inactive ball with pend_launch set, the update SHALL set Yspeed=-LAUNCH_SPEED, Xspeed=0 and active=1, and SHALL leave position unchanged.
REQ-016 The update SHALL clear the ball's pending flags; a new collision or launch event on that same cycle SHALL be retained for the next frame (set wins over clear).
REQ-017 loss[i] SHALL park ball i on the next cycle (position = INITIAL, speeds 0, active=0, pending flags cleared), with priority over the sweep and over collision.
REQ-018 topLeftX and topLeftY SHALL be pos>>>FRAC_BITS (arithmetic shift, floor) and SHALL be registered.
REQ-019 startOfFrame in SWEEP or DONE SHALL be ignored and SHALL set overrun; only reset clears overrun.

Reset
REQ-020 When resetN=0 at a clk edge, the block SHALL set every ball to INITIAL_X/INITIAL_Y with zero speed, set active=0, busy=0 and overrun=0, clear all pending flags, and set the FSM to IDLE.
REQ-021 A reset during SWEEP SHALL abort the sweep with no partial update visible afterward.

Configuration
REQ-022 With macro BALL_BOUNDS_CLAMP_EN defined, the block SHALL clamp the pixel position after integration to X in [0,639-15] and Y in [0,479-15], and SHALL zero the speed component on the clamped axis.
REQ-023 Without BALL_BOUNDS_CLAMP_EN, the block SHALL not limit position, and signed wrap of the position register is permitted.

Verification
REQ-024 Reset, then launch[0] pulse, then 2 frames -> frame1: active[0]=1, Y=337; frame2: Y=334 (21568-160=21408 fp), Yspeed=-159.
REQ-025 Ball0 with Yspeed=+64, collision[0]=1, HitEdgeCode=0001, then frame -> Yspeed after reflect=-62, Yfp decreases by 62, Yspeed ends at -61.
REQ-026 Code 0011 with Xspeed=+40 and Yspeed=+40 -> both reflect: X gets -39, Y gets -39 then -38 after gravity.
REQ-027 Code 0100 with Yspeed=+50 -> no reflection (moving away); Yspeed ends at 51.
REQ-028 NUM_BALLS=4, startOfFrame repeated 2 cycles after the first -> busy for 5 cycles, overrun=1, each ball updated exactly once.
REQ-029 loss[1] on the same cycle as ball1's SWEEP slot -> ball1 parked at (392,337) with active=0; ball0 updates normally.
